// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
package riscv_mem_pkg;

  localparam int unsigned BE_W = 4;

  // Arbiter state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_DONE_I = 3'd3,
    ST_DONE_D = 3'd4
  } arb_state_e;

  // Grant identifiers
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Full-word byte enable used for instruction fetches
  localparam logic [BE_W-1:0] BE_WORD = 4'hF;

endpackage

// File: rtl/arb_wait_timer.sv
// Saturating event counter with clear/enable and a limit indication.
// LOOKAHEAD=0: timeout_c is high while the count sits at LIMIT.
// LOOKAHEAD=1: timeout_c is high in the cycle whose increment reaches LIMIT.
module arb_wait_timer #(
  parameter int unsigned LIMIT     = 255,
  parameter bit          LOOKAHEAD = 1'b0,
  localparam int unsigned CW       = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_c
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_limit;

  assign at_limit = (cnt_q == CW'(LIMIT));

  // Next count: clear wins, then saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_limit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_c = LOOKAHEAD ? (en_i && !clr_i && (cnt_q == CW'(LIMIT - 1)))
                               : at_limit;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port variable-latency memory bus between fetch and data ports.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_WAIT     = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [BE_W-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            bus_err
);

  arb_state_e      state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [BE_W-1:0] mem_be_q, mem_be_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            i_ready_q, i_ready_d;
  logic            d_ready_q, d_ready_d;
  logic            bus_err_q, bus_err_d;

  logic            gnt_id;
  logic            wait_en, wait_clr, wait_fire;
  logic            starve_inc, starve_clr, starve_sat;

  // Bus wait watchdog: fires on the edge where the count reaches MAX_WAIT
  arb_wait_timer #(.LIMIT(MAX_WAIT), .LOOKAHEAD(1'b1)) u_wait_timer (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (wait_clr),
    .en_i      (wait_en),
    .timeout_c (wait_fire)
  );

  // Consecutive data grants taken while a fetch was waiting
  arb_wait_timer #(.LIMIT(STARVE_LIMIT), .LOOKAHEAD(1'b0)) u_starve_timer (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (starve_clr),
    .en_i      (starve_inc),
    .timeout_c (starve_sat)
  );

  // Next-state, launch and completion logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    bus_err_d   = bus_err_q;
    gnt_id      = GNT_D;
    wait_en     = 1'b0;
    wait_clr    = 1'b0;
    starve_inc  = 1'b0;
    starve_clr  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        wait_clr = 1'b1;
        if (i_req || d_req) begin
          gnt_id    = (d_req && !(i_req && starve_sat)) ? GNT_D : GNT_I;
          mem_req_d = 1'b1;
          if (gnt_id == GNT_D) begin
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            starve_inc  = i_req;
            state_d     = ST_BUSY_D;
          end else begin
            mem_we_d    = 1'b0;
            mem_be_d    = BE_WORD;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            starve_clr  = 1'b1;
            state_d     = ST_BUSY_I;
          end
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == ST_BUSY_I) begin
            i_rdata_d = mem_rdata;
          end else if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          wait_en = 1'b1;
          if (wait_fire) begin
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
            if (state_q == ST_BUSY_I) begin
              i_rdata_d = '0;
            end else begin
              d_rdata_d = '0;
            end
          end
        end
        if (mem_ack || wait_fire) begin
          if (state_q == ST_BUSY_I) begin
            i_ready_d = 1'b1;
            state_d   = ST_DONE_I;
          end else begin
            d_ready_d = 1'b1;
            state_d   = ST_DONE_D;
          end
        end
      end

      ST_DONE_I, ST_DONE_D: begin
        wait_clr = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign bus_err   = bus_err_q;

  // Stall requests for the hazard unit
  assign stall_if  = i_req & ~i_ready_q;
  assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_LIMIT=4, MAX_WAIT=8).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(4), .MAX_WAIT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arbitrated access with a 1-cycle ack, started from an IDLE cycle
  task automatic arb_access(input string tag, input bit exp_d);
    tick();
    chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, " mem_addr"}, mem_addr, exp_d ? d_addr : i_addr);
    mem_ack   = 1'b1;
    mem_rdata = exp_d ? (32'hD000_0000 | d_addr) : (32'h1000_0000 | i_addr);
    tick();
    chk({tag, " d_ready"}, 32'(d_ready), 32'(exp_d));
    chk({tag, " i_ready"}, 32'(i_ready), 32'(!exp_d));
    mem_ack = 1'b0;
    if (exp_d) d_addr = d_addr + 32'd4;
    tick();
  endtask

  initial begin
    reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_be = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst i_ready", 32'(i_ready), 32'd0);
    chk("rst d_ready", 32'(d_ready), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst i_rdata", i_rdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);

    // Single fetch: ack in cycle 2, i_ready in cycle 3
    reset = 1'b1; i_req = 1'b1; i_addr = 32'h100;
    #1 chk("f c0 stall_if", 32'(stall_if), 32'd1);
    tick();
    chk("f c1 mem_req", 32'(mem_req), 32'd1);
    chk("f c1 mem_addr", mem_addr, 32'h100);
    chk("f c1 mem_we", 32'(mem_we), 32'd0);
    chk("f c1 mem_be", 32'(mem_be), 32'hF);
    chk("f c1 stall_if", 32'(stall_if), 32'd1);
    tick();
    chk("f c2 mem_req", 32'(mem_req), 32'd1);
    chk("f c2 i_ready", 32'(i_ready), 32'd0);
    chk("f c2 stall_if", 32'(stall_if), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    chk("f c3 i_ready", 32'(i_ready), 32'd1);
    chk("f c3 i_rdata", i_rdata, 32'h0050_0093);
    chk("f c3 mem_req", 32'(mem_req), 32'd0);
    chk("f c3 stall_if", 32'(stall_if), 32'd0);
    i_req = 1'b0; mem_ack = 1'b0;
    tick();
    chk("f c4 i_ready", 32'(i_ready), 32'd0);

    // Simultaneous requests: D store first, then I
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    #1 chk("sim c0 stall_mem", 32'(stall_mem), 32'd1);
    tick();
    chk("sim c1 mem_addr", mem_addr, 32'h2000);
    chk("sim c1 mem_we", 32'(mem_we), 32'd1);
    chk("sim c1 mem_be", 32'(mem_be), 32'h3);
    chk("sim c1 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk("sim c2 d_ready", 32'(d_ready), 32'd1);
    chk("sim c2 i_ready", 32'(i_ready), 32'd0);
    chk("sim c2 d_rdata", d_rdata, 32'd0);
    chk("sim c2 mem_we", 32'(mem_we), 32'd0);
    chk("sim c2 stall_mem", 32'(stall_mem), 32'd0);
    d_req = 1'b0; mem_ack = 1'b0;
    tick();
    chk("sim c3 idle mem_req", 32'(mem_req), 32'd0);
    tick();
    chk("sim c4 mem_req", 32'(mem_req), 32'd1);
    chk("sim c4 mem_addr", mem_addr, 32'h200);
    chk("sim c4 mem_be", 32'(mem_be), 32'hF);
    chk("sim c4 mem_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("sim c5 i_ready", 32'(i_ready), 32'd1);
    chk("sim c5 i_rdata", i_rdata, 32'hCAFE_F00D);
    i_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Starvation: 4 D grants, then I, then D count restarts
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4000;
    arb_access("stv D1", 1'b1);
    arb_access("stv D2", 1'b1);
    arb_access("stv D3", 1'b1);
    arb_access("stv D4", 1'b1);
    arb_access("stv I", 1'b0);
    chk("stv i_rdata", i_rdata, 32'h1000_0300);
    arb_access("stv D5", 1'b1);
    arb_access("stv D6", 1'b1);
    i_req = 1'b0; d_req = 1'b0;
    chk("stv d_rdata", d_rdata, 32'hD000_4014);
    tick();

    // Watchdog: D read never acknowledged
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
    tick();
    chk("wd c1 mem_req", 32'(mem_req), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("wd busy mem_req", 32'(mem_req), 32'd1);
      chk("wd busy bus_err", 32'(bus_err), 32'd0);
    end
    tick();
    chk("wd c9 mem_req", 32'(mem_req), 32'd0);
    chk("wd c9 d_ready", 32'(d_ready), 32'd1);
    chk("wd c9 d_rdata", d_rdata, 32'd0);
    chk("wd c9 bus_err", 32'(bus_err), 32'd1);
    d_req = 1'b0;
    tick();
    chk("wd c10 d_ready", 32'(d_ready), 32'd0);
    tick(); tick();
    chk("wd sticky bus_err", 32'(bus_err), 32'd1);

    // Reset mid-access during BUSY_I
    i_req = 1'b1; i_addr = 32'h600;
    tick();
    chk("rm c1 mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1 chk("rm async mem_req", 32'(mem_req), 32'd0);
    chk("rm async bus_err", 32'(bus_err), 32'd0);
    i_req = 1'b0;
    tick();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    chk("rm stale i_ready", 32'(i_ready), 32'd0);
    chk("rm stale mem_req", 32'(mem_req), 32'd0);
    chk("rm stale i_rdata", i_rdata, 32'd0);
    mem_ack = 1'b0; i_req = 1'b1; i_addr = 32'h700;
    tick();
    chk("rm next mem_req", 32'(mem_req), 32'd1);
    chk("rm next mem_addr", mem_addr, 32'h700);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    chk("rm next i_ready", 32'(i_ready), 32'd1);
    chk("rm next i_rdata", i_rdata, 32'h1111_1111);
    i_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Variable latency store, requester changes mid-access, spurious ack in IDLE
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000; d_wdata = 32'hA5A5_A5A5; d_be = 4'b1100;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("vl mem_req", 32'(mem_req), 32'd1);
      chk("vl mem_addr", mem_addr, 32'h8000);
      chk("vl mem_wdata", mem_wdata, 32'hA5A5_A5A5);
      chk("vl mem_be", 32'(mem_be), 32'hC);
      chk("vl d_ready", 32'(d_ready), 32'd0);
      if (c == 1) begin d_addr = 32'hFFFF_0000; d_wdata = 32'd0; end
      if (c == 2) d_req = 1'b0;
      if (c == 5) begin mem_ack = 1'b1; mem_rdata = 32'h5555_5555; end
    end
    tick();
    chk("vl done d_ready", 32'(d_ready), 32'd1);
    chk("vl done mem_req", 32'(mem_req), 32'd0);
    chk("vl done d_rdata", d_rdata, 32'd0);
    chk("vl done bus_err", 32'(bus_err), 32'd0);
    mem_ack = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    chk("sp mem_req", 32'(mem_req), 32'd0);
    chk("sp d_ready", 32'(d_ready), 32'd0);
    chk("sp i_ready", 32'(i_ready), 32'd0);
    chk("sp d_rdata", d_rdata, 32'd0);
    mem_ack = 1'b0;
    tick();
    chk("sp after mem_req", 32'(mem_req), 32'd0);
    chk("sp after i_ready", 32'(i_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
